// File: rtl/sccb_config.sv
// SCCB write master for OV7670 register setup: walks a (reg, value) table from
// an external ROM and emits one 3-phase write per entry, with delay and end markers.
module sccb_config #(
   parameter int unsigned QUARTER      = 163,
   parameter logic [7:0]  CAM_ID       = 8'h42,
   parameter int unsigned DELAY_CYCLES = 65000
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        start_in,
   output logic [7:0]  rom_addr_out,
   input  logic [15:0] rom_data_in,
   output logic        sioc_out,
   output logic        siod_out,
   output logic        siod_oe_out,
   output logic        busy_out,
   output logic        done_out,
   output logic [7:0]  count_out
);

   localparam int unsigned QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
   localparam int unsigned DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
   localparam logic [QW-1:0] QLAST = QW'(QUARTER - 1);
   localparam logic [DW-1:0] DLAST = DW'(DELAY_CYCLES - 1);

   typedef enum logic [3:0] {
      StIdle, StFetch, StCheck, StStart, StByte, StStop, StGap, StDelay, StDone
   } state_t;

   state_t        state_q, state_d;
   logic [QW-1:0] qcnt_q, qcnt_d;
   logic [1:0]    qidx_q, qidx_d;
   logic [4:0]    bit_q, bit_d;
   logic [26:0]   shreg_q, shreg_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic [7:0]    addr_q, addr_d;
   logic [7:0]    count_q, count_d;
   logic          qtick;

   assign qtick        = (qcnt_q == QLAST);
   assign rom_addr_out = addr_q;
   assign count_out    = count_q;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= StIdle;
         qcnt_q  <= '0;
         qidx_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         dcnt_q  <= '0;
         addr_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         qcnt_q  <= qcnt_d;
         qidx_q  <= qidx_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         dcnt_q  <= dcnt_d;
         addr_q  <= addr_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      qcnt_d      = qtick ? '0 : qcnt_q + QW'(1);
      qidx_d      = qidx_q;
      bit_d       = bit_q;
      shreg_d     = shreg_q;
      dcnt_d      = dcnt_q;
      addr_d      = addr_q;
      count_d     = count_q;
      sioc_out    = 1'b1;
      siod_out    = 1'b1;
      siod_oe_out = 1'b1;
      busy_out    = 1'b1;
      done_out    = 1'b0;
      unique case (state_q)
         StIdle, StDone: begin
            busy_out = 1'b0;
            done_out = (state_q == StDone);
            if (start_in) begin
               count_d = '0;
               addr_d  = '0;
               state_d = StFetch;
            end
         end
         StFetch: state_d = StCheck;
         StCheck: begin
            if (rom_data_in == 16'hFFFF) begin
               state_d = StDone;
            end else if (rom_data_in[15:8] == 8'hF0) begin
               dcnt_d  = '0;
               state_d = StDelay;
            end else begin
               // Ninth bit of each phase is a released ACK slot; its value is unused.
               shreg_d = {CAM_ID, 1'b1, rom_data_in[15:8], 1'b1, rom_data_in[7:0], 1'b1};
               qcnt_d  = '0;
               qidx_d  = '0;
               state_d = StStart;
            end
         end
         StStart: begin
            sioc_out = (qidx_q == 2'd0);
            siod_out = 1'b0;
            if (qtick) begin
               qidx_d = qidx_q + 2'd1;
               if (qidx_q == 2'd1) begin
                  qidx_d  = '0;
                  bit_d   = '0;
                  state_d = StByte;
               end
            end
         end
         StByte: begin
            sioc_out    = (qidx_q == 2'd1) || (qidx_q == 2'd2);
            siod_out    = shreg_q[26];
            siod_oe_out = !((bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == 5'd26));
            if (qtick) begin
               qidx_d = qidx_q + 2'd1;
               if (qidx_q == 2'd3) begin
                  shreg_d = {shreg_q[25:0], 1'b0};
                  bit_d   = bit_q + 5'd1;
                  if (bit_q == 5'd26) state_d = StStop;
               end
            end
         end
         StStop: begin
            sioc_out = (qidx_q != 2'd0);
            siod_out = (qidx_q == 2'd2);
            if (qtick) begin
               qidx_d = qidx_q + 2'd1;
               if (qidx_q == 2'd2) begin
                  qidx_d  = '0;
                  state_d = StGap;
               end
            end
         end
         StGap: begin
            if (qtick) begin
               qidx_d = qidx_q + 2'd1;
               if (qidx_q == 2'd3) begin
                  count_d = count_q + 8'd1;
                  if (addr_q == 8'hFF) begin
                     state_d = StDone;
                  end else begin
                     addr_d  = addr_q + 8'd1;
                     state_d = StFetch;
                  end
               end
            end
         end
         StDelay: begin
            dcnt_d = dcnt_q + DW'(1);
            if (dcnt_q == DLAST) begin
               if (addr_q == 8'hFF) begin
                  state_d = StDone;
               end else begin
                  addr_d  = addr_q + 8'd1;
                  state_d = StFetch;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_sccb_config.sv
// Directed bench for sccb_config: frame contents and timing, delay and end markers,
// ignored restarts, mid-frame reset and the 256-entry address limit.
module tb_sccb_config;

   logic        clk_65mhz = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data;
   logic        sioc, siod, oe, busy, done;
   logic [7:0]  count;

   logic        start_f = 1'b0;
   logic [7:0]  rom_addr_f;
   logic [15:0] rom_data_f;
   logic        sioc_f, siod_f, oe_f, busy_f, done_f;
   logic [7:0]  count_f;

   logic [15:0] rom [256];

   int n_cmp = 0;
   int n_bad = 0;

   int          cap_rise, cap_edges, cap_fall, cap_done, cap_addr_chg;
   logic [26:0] cap_bits, cap_oe;
   logic [7:0]  cap_addr0, last_addr;

   localparam logic [26:0] OE_EXP = 27'b111111110_111111110_111111110;

   always #5 clk_65mhz = ~clk_65mhz;

   always_ff @(posedge clk_65mhz) rom_data <= rom[rom_addr];
   always_ff @(posedge clk_65mhz) rom_data_f <= 16'h1280;

   sccb_config #(.QUARTER(4), .CAM_ID(8'h42), .DELAY_CYCLES(20)) dut (
      .clk_in(clk_65mhz), .rst_in(rst), .start_in(start), .rom_addr_out(rom_addr),
      .rom_data_in(rom_data), .sioc_out(sioc), .siod_out(siod), .siod_oe_out(oe),
      .busy_out(busy), .done_out(done), .count_out(count)
   );

   sccb_config #(.QUARTER(1), .CAM_ID(8'h42), .DELAY_CYCLES(20)) dut_fast (
      .clk_in(clk_65mhz), .rst_in(rst), .start_in(start_f), .rom_addr_out(rom_addr_f),
      .rom_data_in(rom_data_f), .sioc_out(sioc_f), .siod_out(siod_f), .siod_oe_out(oe_f),
      .busy_out(busy_f), .done_out(done_f), .count_out(count_f)
   );

   // Returns at the negedge just after the accepting posedge (FETCH cycle, k=0).
   task automatic pulse_start();
      @(negedge clk_65mhz) start = 1'b1;
      @(negedge clk_65mhz) start = 1'b0;
   endtask

   task automatic load_rom(input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
      for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
      rom[0] = e0;
      rom[1] = e1;
      rom[2] = e2;
   endtask

   // Observes one run from k=0 until done_out; optionally pulses start at k=pulse_at.
   task automatic capture(input int pulse_at);
      logic ps, pd;
      ps = 1'b1; pd = 1'b1;
      cap_rise = 0; cap_edges = 0; cap_fall = -1; cap_done = -1; cap_addr_chg = 0;
      cap_bits = '0; cap_oe = '0; cap_addr0 = rom_addr; last_addr = rom_addr;
      for (int k = 0; k < 3000; k++) begin
         if (k == pulse_at) start = 1'b1;
         else start = 1'b0;
         if (sioc && !ps) begin
            if (cap_rise < 27) begin
               cap_bits = {cap_bits[25:0], siod};
               cap_oe   = {cap_oe[25:0], oe};
            end
            cap_rise++;
         end
         if (sioc && ps && (siod !== pd)) cap_edges++;
         if (cap_fall < 0 && sioc && !siod) cap_fall = k;
         if (rom_addr !== last_addr) begin
            cap_addr_chg++;
            last_addr = rom_addr;
         end
         if (done) begin
            cap_done = k;
            break;
         end
         ps = sioc; pd = siod;
         @(negedge clk_65mhz);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk_65mhz);
      n_cmp++; if ({sioc, siod, oe} !== 3'b111) begin
         n_bad++; $display("FAIL reset_bus: got %b expected 111", {sioc, siod, oe});
      end
      n_cmp++; if ({busy, done} !== 2'b00) begin
         n_bad++; $display("FAIL reset_flags: got %b expected 00", {busy, done});
      end
      n_cmp++; if (rom_addr !== 8'd0) begin
         n_bad++; $display("FAIL reset_addr: got %0d expected 0", rom_addr);
      end
      n_cmp++; if (count !== 8'd0) begin
         n_bad++; $display("FAIL reset_count: got %0d expected 0", count);
      end
      rst = 1'b0;
      @(negedge clk_65mhz);
   endtask

   task automatic test_write();
      load_rom(16'h1280, 16'hFFFF, 16'hFFFF);
      pulse_start();
      n_cmp++; if (busy !== 1'b1) begin
         n_bad++; $display("FAIL write_busy_early: got %b expected 1", busy);
      end
      capture(-1);
      n_cmp++; if (cap_fall !== 2) begin
         n_bad++; $display("FAIL write_first_fall: got k=%0d expected k=2", cap_fall);
      end
      n_cmp++; if ({cap_bits[26:19], cap_bits[17:10], cap_bits[8:1]} !== 24'h421280) begin
         n_bad++; $display("FAIL write_bytes: got %h expected 421280",
                           {cap_bits[26:19], cap_bits[17:10], cap_bits[8:1]});
      end
      n_cmp++; if (cap_oe !== OE_EXP) begin
         n_bad++; $display("FAIL write_oe: got %b expected %b", cap_oe, OE_EXP);
      end
      n_cmp++; if (cap_rise !== 28) begin
         n_bad++; $display("FAIL write_rises: got %0d expected 28 (27 bits + stop)", cap_rise);
      end
      n_cmp++; if (cap_edges !== 2) begin
         n_bad++; $display("FAIL write_siod_while_high: got %0d expected 2", cap_edges);
      end
      n_cmp++; if (cap_done !== 472) begin
         n_bad++; $display("FAIL write_done_time: got k=%0d expected k=472", cap_done);
      end
      n_cmp++; if ({count, busy} !== {8'd1, 1'b0}) begin
         n_bad++; $display("FAIL write_count_busy: got %0d/%b expected 1/0", count, busy);
      end
      n_cmp++; if (rom_addr !== 8'd1) begin
         n_bad++; $display("FAIL write_final_addr: got %0d expected 1", rom_addr);
      end
   endtask

   task automatic test_empty();
      logic toggled;
      load_rom(16'hFFFF, 16'hFFFF, 16'hFFFF);
      toggled = 1'b0;
      pulse_start();
      n_cmp++; if (count !== 8'd0) begin
         n_bad++; $display("FAIL empty_count_cleared: got %0d expected 0", count);
      end
      @(negedge clk_65mhz);
      n_cmp++; if (done !== 1'b0) begin
         n_bad++; $display("FAIL empty_done_early: got %b expected 0", done);
      end
      @(negedge clk_65mhz);
      n_cmp++; if (done !== 1'b1) begin
         n_bad++; $display("FAIL empty_done_at_3: got %b expected 1", done);
      end
      for (int i = 0; i < 10; i++) begin
         if (sioc !== 1'b1) toggled = 1'b1;
         @(negedge clk_65mhz);
      end
      n_cmp++; if (toggled !== 1'b0) begin
         n_bad++; $display("FAIL empty_sioc_toggled: got %b expected 0", toggled);
      end
   endtask

   task automatic test_delay();
      load_rom(16'hF000, 16'h1101, 16'hFFFF);
      pulse_start();
      capture(-1);
      n_cmp++; if (cap_fall !== 24) begin
         n_bad++; $display("FAIL delay_first_fall: got k=%0d expected k=24", cap_fall);
      end
      n_cmp++; if ({cap_bits[26:19], cap_bits[17:10], cap_bits[8:1]} !== 24'h421101) begin
         n_bad++; $display("FAIL delay_bytes: got %h expected 421101",
                           {cap_bits[26:19], cap_bits[17:10], cap_bits[8:1]});
      end
      n_cmp++; if (cap_done !== 494) begin
         n_bad++; $display("FAIL delay_done_time: got k=%0d expected k=494", cap_done);
      end
      n_cmp++; if (count !== 8'd1) begin
         n_bad++; $display("FAIL delay_count: got %0d expected 1", count);
      end
      n_cmp++; if ({cap_addr_chg, rom_addr} !== {32'd2, 8'd2}) begin
         n_bad++; $display("FAIL delay_addr: got %0d changes/%0d expected 2/2",
                           cap_addr_chg, rom_addr);
      end
   endtask

   task automatic test_back_to_back();
      load_rom(16'h1280, 16'hFFFF, 16'hFFFF);
      pulse_start();
      capture(100);
      n_cmp++; if ({cap_bits[26:19], cap_bits[17:10], cap_bits[8:1]} !== 24'h421280) begin
         n_bad++; $display("FAIL midstart_bytes: got %h expected 421280",
                           {cap_bits[26:19], cap_bits[17:10], cap_bits[8:1]});
      end
      n_cmp++; if (cap_done !== 472) begin
         n_bad++; $display("FAIL midstart_done_time: got k=%0d expected k=472", cap_done);
      end
      n_cmp++; if ({cap_addr0, cap_addr_chg, rom_addr} !== {8'd0, 32'd1, 8'd1}) begin
         n_bad++; $display("FAIL midstart_addr_seq: got %0d,%0d,%0d expected 0,1,1",
                           cap_addr0, cap_addr_chg, rom_addr);
      end
      repeat (3) @(negedge clk_65mhz);
      pulse_start();
      n_cmp++; if ({rom_addr, count, busy, done} !== {8'd0, 8'd0, 1'b1, 1'b0}) begin
         n_bad++; $display("FAIL restart_state: got addr %0d count %0d busy %b done %b expected 0 0 1 0",
                           rom_addr, count, busy, done);
      end
      capture(-1);
      n_cmp++; if ({cap_done, count} !== {32'd472, 8'd1}) begin
         n_bad++; $display("FAIL restart_run: got k=%0d count %0d expected k=472 count 1",
                           cap_done, count);
      end
   endtask

   task automatic test_reset_mid();
      load_rom(16'h1280, 16'hFFFF, 16'hFFFF);
      pulse_start();
      repeat (10) @(negedge clk_65mhz);
      n_cmp++; if ({sioc, siod, oe, busy} !== 4'b0011) begin
         n_bad++; $display("FAIL midreset_precond: got %b expected 0011", {sioc, siod, oe, busy});
      end
      rst = 1'b1;
      @(negedge clk_65mhz);
      n_cmp++; if ({sioc, siod, oe, busy, done} !== 5'b11100) begin
         n_bad++; $display("FAIL midreset_outputs: got %b expected 11100",
                           {sioc, siod, oe, busy, done});
      end
      n_cmp++; if ({rom_addr, count} !== 16'd0) begin
         n_bad++; $display("FAIL midreset_addr_count: got %0d/%0d expected 0/0", rom_addr, count);
      end
      rst = 1'b0;
      @(negedge clk_65mhz);
   endtask

   task automatic test_addr_limit();
      int done_k;
      done_k = -1;
      @(negedge clk_65mhz) start_f = 1'b1;
      @(negedge clk_65mhz) start_f = 1'b0;
      for (int k = 0; k < 40000; k++) begin
         if (done_f) begin
            done_k = k;
            break;
         end
         @(negedge clk_65mhz);
      end
      n_cmp++; if (done_k !== 30464) begin
         n_bad++; $display("FAIL limit_done_time: got k=%0d expected k=30464", done_k);
      end
      n_cmp++; if (rom_addr_f !== 8'd255) begin
         n_bad++; $display("FAIL limit_addr: got %0d expected 255", rom_addr_f);
      end
      n_cmp++; if ({count_f, busy_f} !== {8'd0, 1'b0}) begin
         n_bad++; $display("FAIL limit_count_busy: got %0d/%b expected 0/0", count_f, busy_f);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
      test_reset();
      test_write();
      test_empty();
      test_delay();
      test_back_to_back();
      test_reset_mid();
      test_addr_limit();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
